regfile_wr_arbiter: RTL and testbench

Arbitrates the integer register file's single write port between the core writeback stage and the GEMM accelerator result return path. Accelerator writes are buffered in a small FIFO and drained only in cycles where the core does not write. A per-register pending scoreboard tells decode when a source or destination register still has an accelerator write outstanding, so decode can stall. The block sits between writeback/accelerator and the register file's `write_reg`/`rd`/`data_in` inputs.

---
 rtl/regfile_arb_pkg.sv | 14 +
 rtl/arb_fifo.sv | 55 +++++
 rtl/regfile_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 1 << REG_AW;

  // One buffered accelerator register write.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } acc_wr_t;

endpackage

// File: rtl/arb_fifo.sv
// Synchronous FIFO of accelerator register writes.
// The pointers carry one bit beyond the address width, so full and empty
// are told apart without a separate flag.
module arb_fifo
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  acc_wr_t                din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output acc_wr_t                head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  acc_wr_t     mem_q [DEPTH];

  assign count = wr_q - rd_q;
  assign empty = (wr_q == rd_q);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem_q[rd_q[AW-1:0]];

  // Pointer advance; overflow and underflow requests are ignored.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !full) wr_d = wr_q + 1'b1;
    if (pop && !empty) rd_d = rd_q + 1'b1;
  end

  // Pointer registers, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Entry storage; contents are meaningless while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, accelerator
// writes are buffered and drained in core-idle cycles, and a per-register
// pending scoreboard drives the decode hazard stall.
// Optional feature macro: ARB_STARVE_GUARD_EN (forced writeback bubble after
// STARVE_LIMIT consecutive blocked drains).
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_we,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_data,
  input  logic                   acc_valid,
  output logic                   acc_ready,
  input  logic [4:0]             acc_rd,
  input  logic [31:0]            acc_data,
  input  logic [4:0]             dec_rs1,
  input  logic [4:0]             dec_rs2,
  input  logic [4:0]             dec_rd,
  output logic                   hazard_stall,
  output logic                   write_reg,
  output logic [4:0]             rd,
  output logic [31:0]            data_in,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   force_bubble
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("regfile_wr_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic             core_eff;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  acc_wr_t          head;
  acc_wr_t          din;
  logic [NREGS-1:0] busy_q, busy_d;

  assign core_eff = wb_we && (wb_rd != '0);
  assign pop      = !core_eff && !empty;

  // Full blocks acceptance even when the head drains this cycle, and a
  // register with a queued write may not be queued again.
  assign acc_ready = reset && !full && ((acc_rd == '0) || !busy_q[acc_rd]);
  assign push      = acc_valid && acc_ready && (acc_rd != '0);

  assign din.rd   = acc_rd;
  assign din.data = acc_data;

  arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .count (fifo_count),
    .head  (head)
  );

  // Write-port mux: core pass-through, else FIFO head, else idle zeros.
  always_comb begin
    write_reg = 1'b0;
    rd        = '0;
    data_in   = '0;
    if (core_eff) begin
      write_reg = 1'b1;
      rd        = wb_rd;
      data_in   = wb_data;
    end else if (!empty) begin
      write_reg = 1'b1;
      rd        = head.rd;
      data_in   = head.data;
    end
  end

  // Scoreboard next state: drain clears, accept sets; the accept rule keeps
  // the two from ever naming the same register in one cycle.
  always_comb begin
    busy_d = busy_q;
    if (pop)  busy_d[head.rd] = 1'b0;
    if (push) busy_d[acc_rd]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign hazard_stall = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          bubble_q, bubble_d;

  // Count consecutive blocked drains; on the limit, request one bubble and
  // restart. A non-empty FIFO that does not pop is necessarily blocked.
  always_comb begin
    starve_d = starve_q;
    bubble_d = 1'b0;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q == SW'(STARVE_LIMIT - 1)) begin
      starve_d = '0;
      bubble_d = 1'b1;
    end else begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starve counter and registered bubble request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
      bubble_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      bubble_q <= bubble_d;
    end
  end

  assign force_bubble = bubble_q;
`else
  assign force_bubble = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_regfile_wr_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        acc_valid;
  logic        acc_ready;
  logic [4:0]  acc_rd;
  logic [31:0] acc_data;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        hazard_stall;
  logic        write_reg;
  logic [4:0]  rd;
  logic [31:0] data_in;
  logic [2:0]  fifo_count;
  logic        force_bubble;

  regfile_wr_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .acc_rd       (acc_rd),
    .acc_data     (acc_data),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .hazard_stall (hazard_stall),
    .write_reg    (write_reg),
    .rd           (rd),
    .data_in      (data_in),
    .fifo_count   (fifo_count),
    .force_bubble (force_bubble)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: the pending accelerator writes, in order.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int unsigned starve = 0;
  bit          bubble = 1'b0;

  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive, check combinational/registered outputs against
  // the model, advance the model, then let the edge happen.
  task automatic step(input logic rst, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wdat, input logic av, input logic [4:0] ard,
                      input logic [31:0] adat, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] r3, output bit taken);
    bit          core, ready, drain;
    bit          e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    ent_t        e;
    @(negedge clk);
    // The core never writes while a bubble is requested.
    core      = rst && we && !bubble && (wrd != 5'd0);
    reset     = rst;
    wb_we     = we && !bubble;
    wb_rd     = wrd;
    wb_data   = wdat;
    acc_valid = av;
    acc_rd    = ard;
    acc_data  = adat;
    dec_rs1   = r1;
    dec_rs2   = r2;
    dec_rd    = r3;
    #1;
    core = (we && !bubble && (wrd != 5'd0));
    if (core)            begin e_wr = 1'b1; e_rd = wrd;     e_data = wdat;       end
    else if (q.size > 0) begin e_wr = 1'b1; e_rd = q[0].rd; e_data = q[0].data;  end
    else                 begin e_wr = 1'b0; e_rd = 5'd0;    e_data = 32'd0;      end
    ready = rst && (q.size() < DEPTH) && (ard == 5'd0 || !pending(ard));
    chk("write_reg",    32'(write_reg),    32'(e_wr));
    chk("rd",           32'(rd),           32'(e_rd));
    chk("data_in",      data_in,           e_data);
    chk("acc_ready",    32'(acc_ready),    32'(ready));
    chk("hazard_stall", 32'(hazard_stall), 32'(pending(r1) | pending(r2) | pending(r3)));
    chk("fifo_count",   32'(fifo_count),   32'(q.size()));
    chk("force_bubble", 32'(force_bubble), 32'(bubble));
    taken = av && ready;
    if (!rst) begin
      q.delete();
      starve = 0;
      bubble = 1'b0;
    end else begin
      drain = !core && (q.size() > 0);
`ifdef ARB_STARVE_GUARD_EN
      bubble = 1'b0;
      if (q.size() == 0 || drain) starve = 0;
      else if (starve + 1 == LIMIT) begin starve = 0; bubble = 1'b1; end
      else starve++;
`endif
      if (drain) void'(q.pop_front());
      if (taken && ard != 5'd0) begin
        e.rd = ard; e.data = adat;
        q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  bit t;

  initial begin
    reset = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    acc_valid = 1'b0; acc_rd = '0; acc_data = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;

    // Reset state.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, t);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, t);

    // Idle drain of x5.
    step(1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0, 0, t);
    step(1, 0, 0, 0, 0, 0, 0, 5, 0, 0, t);
    step(1, 0, 0, 0, 0, 0, 0, 5, 0, 0, t);

    // Core priority: queue x1..x3 under core writes to x7, hold 4 more cycles.
    for (int i = 1; i <= 3; i++)
      step(1, 1, 7, 32'h7000_0000 + 32'(i), 1, 5'(i), 32'hA000_0000 + 32'(i), 1, 2, 3, t);
    for (int i = 0; i < 4; i++)
      step(1, 1, 7, 32'h7700_0000 + 32'(i), 0, 0, 0, 1, 2, 3, t);
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 0, 0, 0, 0, 1, 2, 3, t);

    // Full FIFO and duplicate register.
    for (int i = 1; i <= 4; i++)
      step(1, 1, 9, 32'h9999_0000, 1, 5'(i), 32'hB000_0000 + 32'(i), 0, 0, 0, t);
    step(1, 1, 9, 32'h9999_0001, 1, 5, 32'hB000_0005, 0, 0, 0, t);
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 0, 1, 2, 32'hC000_0002, 2, 0, 0, t);
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, 0, 0, 0, 2, 4, 0, t);

    // x0 handling: discarded accelerator write, x0 core write lets a drain through.
    step(1, 0, 0, 0, 1, 0, 32'h1234_5678, 0, 0, 0, t);
    step(1, 1, 8, 32'h8888_8888, 1, 6, 32'h6666_6666, 6, 0, 0, t);
    step(1, 1, 0, 32'h0BAD_0BAD, 1, 0, 32'h0000_0001, 6, 0, 0, t);
    step(1, 0, 0, 0, 0, 0, 0, 6, 0, 0, t);

    // Reset with two entries queued.
    step(1, 1, 3, 32'h3333_3333, 1, 10, 32'hAAAA_0010, 10, 11, 0, t);
    step(1, 1, 3, 32'h3333_3334, 1, 11, 32'hAAAA_0011, 10, 11, 0, t);
    step(0, 1, 3, 32'h3333_3335, 1, 12, 32'hAAAA_0012, 10, 11, 12, t);
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 0, 0, 0, 10, 11, 12, t);

    // Starvation: one queued entry against a continuously writing core.
    step(1, 1, 4, 32'h4444_0000, 1, 20, 32'h2020_2020, 20, 0, 0, t);
    for (int i = 1; i <= 14; i++)
      step(1, 1, 4, 32'h4444_0000 + 32'(i), 0, 0, 0, 20, 0, 0, t);
    for (int i = 0; i < 2; i++)
      step(1, 0, 0, 0, 0, 0, 0, 20, 0, 0, t);

    // Randomized traffic with a request held until accepted.
    begin
      bit          pv = 1'b0;
      logic [4:0]  prd = '0;
      logic [31:0] pdat = '0;
      for (int c = 0; c < 3000; c++) begin
        if (!pv && ($urandom_range(2) == 0)) begin
          pv = 1'b1; prd = 5'($urandom_range(7)); pdat = $urandom;
        end
        step(($urandom_range(199) != 0), ($urandom_range(99) < 60), 5'($urandom_range(7)),
             $urandom, pv, prd, pdat, 5'($urandom_range(7)), 5'($urandom_range(7)),
             5'($urandom_range(7)), t);
        if (t) pv = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
